screen_rect_filler: RTL

Initiator on the screen-writer interface: accepts rectangle-fill requests (position, size, colour), clips them to the visible screen and drives the screen_start / screen_done handshake so the screen writer sweeps the rectangle while this block supplies the pixel colour. It sits beside draw_triangle as a second screen-interface initiator. The pipe mesh controller uses it to clear the frame, or a HUD region, between mesh draws.

---
 rtl/screen_pkg.sv | 27 ++
 rtl/rect_req_fifo.sv | 51 +++++
 rtl/screen_rect_filler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - screen geometry, rectangle-filler FSM states and request record
package screen_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  // Request record field widths; the filler's WIDTH/COLOUR_WIDTH must not exceed these.
  localparam int unsigned COORD_W  = 32;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLIP,
    START,
    WAIT,
    FIN
  } fill_state_t;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    logic [COLOUR_W-1:0] colour;
  } rect_req_t;

endpackage

// File: rtl/rect_req_fifo.sv
// rtl/rect_req_fifo.sv - synchronous first-word-fall-through FIFO of fill requests
module rect_req_fifo
  import screen_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type payload_t = rect_req_t,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  payload_t       wr_data,
  input  logic           pop,
  output payload_t       rd_data,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  payload_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/screen_rect_filler.sv
// rtl/screen_rect_filler.sv - clips queued rectangle fills and drives the screen-writer handshake
// SCREEN_RECT_XOR_EN defined: pixel colour is old_screen_colour XOR fill colour.
module screen_rect_filler
  import screen_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned COLOUR_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WIDTH-1:0]        req_x,
  input  logic [WIDTH-1:0]        req_y,
  input  logic [WIDTH-1:0]        req_w,
  input  logic [WIDTH-1:0]        req_h,
  input  logic [COLOUR_WIDTH-1:0] req_colour,
  output logic                    busy,
  output logic                    done,
  output logic                    screen_start,
  output logic [COLOUR_WIDTH-1:0] new_screen_colour,
  output logic [WIDTH-1:0]        screen_x_min,
  output logic [WIDTH-1:0]        screen_y_min,
  output logic [WIDTH-1:0]        screen_x_range,
  output logic [WIDTH-1:0]        screen_y_range,
  input  logic [WIDTH-1:0]        screen_x,
  input  logic [WIDTH-1:0]        screen_y,
  input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
  input  logic                    screen_done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fill_state_t       state;
  fill_state_t       state_next;
  rect_req_t         push_data;
  rect_req_t         head;
  rect_req_t         work;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic              ready_q;

  assign req_ready = ready_q;
  assign push      = req_valid && ready_q;
  assign push_data = '{
    x:      COORD_W'(req_x),
    y:      COORD_W'(req_y),
    w:      COORD_W'(req_w),
    h:      COORD_W'(req_h),
    colour: COLOUR_W'(req_colour)
  };

  rect_req_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .payload_t (rect_req_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // req_ready is registered, so it tracks the count as it will be after this edge.
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  logic [COORD_W-1:0] x_room;
  logic [COORD_W-1:0] y_room;
  logic [COORD_W-1:0] x_span;
  logic [COORD_W-1:0] y_span;
  logic               rect_empty;

  // Room to the screen edge is only meaningful when the origin is on screen; x + w is never formed.
  assign x_room     = COORD_W'(SCREEN_W) - work.x;
  assign y_room     = COORD_W'(SCREEN_H) - work.y;
  assign x_span     = (work.w < x_room) ? work.w : x_room;
  assign y_span     = (work.h < y_room) ? work.h : y_room;
  assign rect_empty = (work.x >= COORD_W'(SCREEN_W)) || (work.y >= COORD_W'(SCREEN_H)) ||
                      (work.w == '0) || (work.h == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    screen_start = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = CLIP;
        end
      end
      CLIP:  state_next = rect_empty ? FIN : START;
      START: begin
        screen_start = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (screen_done) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q        <= 1'b0;
      work           <= '0;
      screen_x_min   <= '0;
      screen_y_min   <= '0;
      screen_x_range <= '0;
      screen_y_range <= '0;
    end else begin
      ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
      if (pop) work <= head;
      if (state == CLIP && !rect_empty) begin
        screen_x_min   <= WIDTH'(work.x);
        screen_y_min   <= WIDTH'(work.y);
        screen_x_range <= WIDTH'(x_span);
        screen_y_range <= WIDTH'(y_span);
      end
    end
  end

  logic [COLOUR_WIDTH-1:0] fill_colour;
  logic [COLOUR_WIDTH-1:0] pixel_colour;

  assign fill_colour = COLOUR_WIDTH'(work.colour);

`ifdef SCREEN_RECT_XOR_EN
  assign pixel_colour = old_screen_colour ^ fill_colour;
`else
  assign pixel_colour = fill_colour;
`endif

  assign new_screen_colour = (state == WAIT) ? pixel_colour : '0;
  assign busy              = !fifo_empty || (state != IDLE);

  // The writer owns the sweep, so its pixel address is observed but not needed here.
  logic unused_inputs;
  assign unused_inputs = ^{screen_x, screen_y, old_screen_colour, fifo_full};

endmodule
